// File: rtl/solo_squash_pkg.sv
// Register map constants and small helpers shared by the Solo Squash Wishbone register block.
package solo_squash_pkg;

  localparam logic [7:0] OFF_CTRL        = 8'h00;
  localparam logic [7:0] OFF_STATUS      = 8'h04;
  localparam logic [7:0] OFF_FRAME_COUNT = 8'h08;
  localparam logic [7:0] OFF_SCRATCH     = 8'h0C;
  localparam logic [7:0] OFF_ID          = 8'h10;

  localparam int unsigned CTRL_GPIO_READY_BIT = 0;
  localparam int unsigned CTRL_SW_RESET_BIT   = 1;
  localparam int unsigned CTRL_SW_PAUSE_BIT   = 2;
  localparam int unsigned CTRL_NEW_GAME_BIT   = 3;

  localparam int unsigned STATUS_VSYNC_BIT   = 0;
  localparam int unsigned STATUS_SPEAKER_BIT = 1;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5351_5348;

  typedef enum logic [2:0] {
    RegCtrl,
    RegStatus,
    RegFrameCount,
    RegScratch,
    RegId,
    RegNone
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [7:0] off);
    reg_sel_e sel;
    case (off)
      OFF_CTRL:        sel = RegCtrl;
      OFF_STATUS:      sel = RegStatus;
      OFF_FRAME_COUNT: sel = RegFrameCount;
      OFF_SCRATCH:     sel = RegScratch;
      OFF_ID:          sel = RegId;
      default:         sel = RegNone;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_q,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_q;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/solo_squash_wb_regs_if.sv
// Wishbone classic slave bus between the Caravel CPU (master) and the register block (slave).
interface solo_squash_wb_regs_if;

  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/solo_squash_edge_counter.sv
// Rising-edge detector feeding a wrapping counter; a synchronous clear takes priority over a count.
module solo_squash_edge_counter
  import solo_squash_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sig,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count
);

  logic             r_sig_q;
  logic [WIDTH-1:0] r_count;
  logic             w_rise;

  assign w_rise  = i_sig & ~r_sig_q;
  assign o_count = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sig_q <= 1'b0;
      r_count <= '0;
    end else begin
      r_sig_q <= i_sig;
      if (i_clear) begin
        r_count <= '0;
      end else if (w_rise) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/solo_squash_wb_regs.sv
// Wishbone register window for Solo Squash: control levels, status, frame counter, scratch and ID.
module solo_squash_wb_regs
  import solo_squash_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ID_VALUE  = ID_VALUE_DEFAULT
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  solo_squash_wb_regs_if.slave  wbs,
  input  logic                  vsync_i,
  input  logic                  speaker_i,
  output logic                  sw_gpio_ready_o,
  output logic                  sw_reset_o,
  output logic                  sw_pause_o,
  output logic                  new_game_pulse_o
);

  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_gpio_ready;
  logic        r_sw_reset;
  logic        r_sw_pause;
  logic        r_new_game;
  logic        r_speaker_seen;
  logic [31:0] r_scratch;

  logic        w_hit;
  logic        w_wr;
  logic        w_rd;
  reg_sel_e    w_reg;
  logic [31:0] w_rd_data;
  logic [31:0] w_frame_count;
  logic        w_ctrl_wr;
  logic        w_status_w1c;
  logic        w_frame_clr;
  logic        w_scratch_wr;

  // Masking with r_ack keeps a held strobe from being acknowledged on back-to-back cycles.
  assign w_hit = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~r_ack &
                 (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_wr  = w_hit & wbs.wbs_we_i;
  assign w_rd  = w_hit & ~wbs.wbs_we_i;
  assign w_reg = decode_offset(wbs.wbs_adr_i[7:0]);

  assign w_ctrl_wr    = w_wr & (w_reg == RegCtrl) & wbs.wbs_sel_i[0];
  assign w_status_w1c = w_wr & (w_reg == RegStatus) & wbs.wbs_sel_i[0] &
                        wbs.wbs_dat_i[STATUS_SPEAKER_BIT];
  assign w_frame_clr  = w_wr & (w_reg == RegFrameCount);
  assign w_scratch_wr = w_wr & (w_reg == RegScratch);

  solo_squash_edge_counter #(
    .WIDTH (32)
  ) u_frame_counter (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_sig   (vsync_i),
    .i_clear (w_frame_clr),
    .o_count (w_frame_count)
  );

  always_comb begin
    w_rd_data = '0;
    unique case (w_reg)
      RegCtrl: begin
        w_rd_data[CTRL_GPIO_READY_BIT] = r_gpio_ready;
        w_rd_data[CTRL_SW_RESET_BIT]   = r_sw_reset;
        w_rd_data[CTRL_SW_PAUSE_BIT]   = r_sw_pause;
      end
      RegStatus: begin
        w_rd_data[STATUS_VSYNC_BIT]   = vsync_i;
        w_rd_data[STATUS_SPEAKER_BIT] = r_speaker_seen;
      end
      RegFrameCount: w_rd_data = w_frame_count;
      RegScratch:    w_rd_data = r_scratch;
      RegId:         w_rd_data = ID_VALUE;
      RegNone:       w_rd_data = '0;
      default:       w_rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack          <= 1'b0;
      r_dat          <= '0;
      r_gpio_ready   <= 1'b0;
      r_sw_reset     <= 1'b0;
      r_sw_pause     <= 1'b0;
      r_new_game     <= 1'b0;
      r_speaker_seen <= 1'b0;
      r_scratch      <= '0;
    end else begin
      r_ack      <= w_hit;
      r_dat      <= w_rd ? w_rd_data : '0;
      r_new_game <= w_ctrl_wr & wbs.wbs_dat_i[CTRL_NEW_GAME_BIT];
      if (w_ctrl_wr) begin
        r_gpio_ready <= wbs.wbs_dat_i[CTRL_GPIO_READY_BIT];
        r_sw_reset   <= wbs.wbs_dat_i[CTRL_SW_RESET_BIT];
        r_sw_pause   <= wbs.wbs_dat_i[CTRL_SW_PAUSE_BIT];
      end
      // A speaker hit in the same cycle as the clear wins.
      r_speaker_seen <= speaker_i | (r_speaker_seen & ~w_status_w1c);
      if (w_scratch_wr) begin
        r_scratch <= merge_bytes(r_scratch, wbs.wbs_dat_i, wbs.wbs_sel_i);
      end
    end
  end

  assign wbs.wbs_ack_o   = r_ack;
  assign wbs.wbs_dat_o   = r_dat;
  assign sw_gpio_ready_o = r_gpio_ready;
  assign sw_reset_o      = r_sw_reset;
  assign sw_pause_o      = r_sw_pause;
  assign new_game_pulse_o = r_new_game;

endmodule

// File: doc/solo_squash_wb_regs.md
SOLO_SQUASH_WB_REGS -- requirements
Module: solo_squash_wb_regs

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000, Wishbone byte-address base of the register window; bits [7:0] are zero.
REQ-002 Parameter ID_VALUE, default 32'h5351_5348, the constant returned by the ID register.
REQ-003 wb_clk_i  input  1  single clock; all logic is rising-edge.
REQ-004 wb_rst_i  input  1  asynchronous, active-high reset.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone strobe, cycle and write enable from the Caravel CPU (initiator).
REQ-006 wbs_sel_i  input  4  byte lane select.
REQ-007 wbs_adr_i, wbs_dat_i  input  32 each  byte address and write data.
REQ-008 wbs_ack_o  output  1  acknowledge; wbs_dat_o  output  32  read data.
REQ-009 vsync_i, speaker_i  input  1 each  game outputs, same clock domain.
REQ-010 sw_gpio_ready_o, sw_reset_o, sw_pause_o  output  1 each  CTRL register levels.
REQ-011 new_game_pulse_o  output  1  one-cycle new-game strobe.

Function
REQ-012 Hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & !wbs_ack_o; only a hit is acknowledged.
REQ-013 Acknowledge latency: wbs_ack_o is high exactly one cycle, in the cycle after the hit; it is never high on two consecutive cycles.
REQ-014 A write takes effect on the same clock edge that raises wbs_ack_o; only lanes with wbs_sel_i set are written.
REQ-015 Read data is registered with wbs_ack_o; wbs_dat_o is 0 whenever wbs_ack_o is low.
REQ-016 Offset wbs_adr_i[7:0] decode: 0x00 CTRL, 0x04 STATUS, 0x08 FRAME_COUNT, 0x0C SCRATCH, 0x10 ID; other offsets in the window are acknowledged, read as 0, and ignore writes.
REQ-017 CTRL (RW): bit0 sw_gpio_ready, bit1 sw_reset, bit2 sw_pause, bit3 new_game (write-1 only, reads 0); other bits read 0.
REQ-018 Writing CTRL bit3 = 1 with sel[0] set drives new_game_pulse_o high for exactly the one cycle following the write edge.
REQ-019 STATUS: bit0 = vsync_i level (RO); bit1 = speaker_seen, sticky, set on any cycle with speaker_i = 1, cleared by writing 1 to bit1 (W1C); other bits read 0.
REQ-020 On a W1C write that coincides with speaker_i = 1, set wins: speaker_seen stays 1.
REQ-021 FRAME_COUNT (32-bit): increments by 1 on each vsync_i rising edge, detected against a registered copy of vsync_i; wraps 0xFFFF_FFFF -> 0.
REQ-022 Any write to FRAME_COUNT clears it to 0 regardless of data or sel; a clear that coincides with a rising edge yields 0.
REQ-023 SCRATCH (RW, 32-bit, per-byte sel) has no side effects; ID (RO) returns ID_VALUE.
REQ-024 Dropping stb or cyc mid-cycle needs no special handling: a hit is complete in one cycle and no state is held pending.

Reset
REQ-025 Reset is asynchronous and active-high on wb_rst_i; while asserted, wbs_ack_o = 0, wbs_dat_o = 0, all CTRL bits = 0, new_game_pulse_o = 0, speaker_seen = 0, FRAME_COUNT = 0, SCRATCH = 0, and the registered vsync copy = 0.
REQ-026 Reset asserted mid-transaction drops wbs_ack_o immediately; the transaction is lost and there are no partial writes.
REQ-027 sw_reset_o is not internally fed back to this block; it does not reset the block.

Structure
REQ-028 A package solo_squash_pkg holds register offset constants (CTRL/STATUS/FRAME_COUNT/SCRATCH/ID), CTRL and STATUS bit indices, and the default ID value.
REQ-029 A single sub-module, solo_squash_edge_counter (rising-edge detect plus 32-bit counter with synchronous clear), implements FRAME_COUNT; all other logic is flat.

Verification
REQ-030 Write 0x0000_000F to CTRL with sel 0xF -> ack one cycle later; sw_gpio_ready/reset/pause = 1; new_game_pulse_o high for exactly 1 cycle; CTRL reads back 0x7.
REQ-031 Write 0xAABB_CCDD to SCRATCH with sel 0x5 after reset -> reads back 0x00BB_00DD; ID reads 0x5351_5348; offset 0x20 reads 0 with ack.
REQ-032 Drive 3 vsync pulses -> FRAME_COUNT reads 3; write FRAME_COUNT in the same cycle as a vsync rising edge -> reads 0.
REQ-033 Preload FRAME_COUNT to 0xFFFF_FFFF via a force hook, then 1 vsync edge -> reads 0.
REQ-034 Pulse speaker_i once -> STATUS bit1 = 1; W1C while speaker_i = 1 -> stays 1; W1C with speaker_i = 0 -> 0.
REQ-035 Hold stb/cyc high for 4 cycles -> ack pattern 0,1,0,1; address 0x3000_0100 -> no ack; assert reset during ack -> ack and dat drop to 0 asynchronously.
